// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : regfile_wb_arbiter                                                |
// | Brief   : Register-file write-port arbiter (fast ALU vs. slow unit) with    |
// |           issue scoreboard and slow-writeback starvation throttle.          |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_issue_valid,
    input  logic [4:0]  i_issue_rs1,
    input  logic [4:0]  i_issue_rs2,
    input  logic [4:0]  i_issue_rd,
    input  logic        i_issue_long,
    output logic        o_issue_stall,
    input  logic        i_fast_valid,
    input  logic [4:0]  i_fast_rd,
    input  logic [31:0] i_fast_data,
    input  logic        i_slow_valid,
    input  logic [4:0]  i_slow_rd,
    input  logic [31:0] i_slow_data,
    output logic        o_slow_ready,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd_data,
    output logic [31:0] o_pending
);

    localparam logic [2:0] c_starve_limit = 3'(STARVE_LIMIT);

    logic [31:0] r_pending;
    logic [2:0]  r_wait_cnt;

    logic        w_fast_req;
    logic        w_slow_accept;
    logic        w_hazard;
    logic        w_issue_fire;
    logic [31:0] w_pending_nxt;

    // Fast writeback cannot be back-pressured, so it always owns the port.
    assign w_fast_req    = i_fast_valid && (i_fast_rd != 5'd0);
    assign o_slow_ready  = !i_rst && !w_fast_req;
    assign w_slow_accept = i_slow_valid && o_slow_ready;

    always_comb begin
        o_rd_addr = 5'd0;
        o_rd_data = 32'd0;
        if (!i_rst) begin
            if (w_fast_req) begin
                o_rd_addr = i_fast_rd;
                o_rd_data = i_fast_data;
            end else if (w_slow_accept) begin
                o_rd_addr = i_slow_rd;
                o_rd_data = i_slow_data;
            end
        end
    end

    // Bit 0 of r_pending is never set, so index 0 can never raise a hazard.
    assign w_hazard = i_issue_valid &&
                      (r_pending[i_issue_rs1] || r_pending[i_issue_rs2] || r_pending[i_issue_rd]);

    assign o_issue_stall = w_hazard || (r_wait_cnt == c_starve_limit) || i_rst;
    assign w_issue_fire  = i_issue_valid && !o_issue_stall;

    always_comb begin
        w_pending_nxt = r_pending;
        if (w_slow_accept && (i_slow_rd != 5'd0)) begin
            w_pending_nxt[i_slow_rd] = 1'b0;
        end
        // Applied after the clear so a same-index set wins.
        if (w_issue_fire && i_issue_long && (i_issue_rd != 5'd0)) begin
            w_pending_nxt[i_issue_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending  <= 32'd0;
            r_wait_cnt <= 3'd0;
        end else begin
            r_pending <= w_pending_nxt;
            if (!i_slow_valid || w_slow_accept) begin
                r_wait_cnt <= 3'd0;
            end else if (r_wait_cnt != c_starve_limit) begin
                r_wait_cnt <= r_wait_cnt + 3'd1;
            end
        end
    end

    assign o_pending = i_rst ? 32'd0 : r_pending;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tb_regfile_wb_arbiter                                             |
// | Brief   : Directed and randomized bench for regfile_wb_arbiter against a    |
// |           behavioural scoreboard/arbitration model.                         |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_long;
    logic        issue_stall;
    logic        fast_valid;
    logic [4:0]  fast_rd;
    logic [31:0] fast_data;
    logic        slow_valid;
    logic [4:0]  slow_rd;
    logic [31:0] slow_data;
    logic        slow_ready;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] pending;

    regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_issue_valid(issue_valid),
        .i_issue_rs1  (issue_rs1),
        .i_issue_rs2  (issue_rs2),
        .i_issue_rd   (issue_rd),
        .i_issue_long (issue_long),
        .o_issue_stall(issue_stall),
        .i_fast_valid (fast_valid),
        .i_fast_rd    (fast_rd),
        .i_fast_data  (fast_data),
        .i_slow_valid (slow_valid),
        .i_slow_rd    (slow_rd),
        .i_slow_data  (slow_data),
        .o_slow_ready (slow_ready),
        .o_rd_addr    (rd_addr),
        .o_rd_data    (rd_data),
        .o_pending    (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: set of registers awaiting a slow writeback, and how
    // long the current slow request has been refused.
    bit [31:0] m_pend;
    int        m_wait;
    bit        last_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0; issue_long = 0;
        fast_valid = 0;  fast_rd = 0;   fast_data = 0;
        slow_valid = 0;  slow_rd = 0;   slow_data = 0;
    endtask

    // Check every output against the model for the current inputs, then
    // advance the model across the next rising edge.
    task automatic step(input string tag);
        bit          fast_req, e_ready, acc, hz, e_stall;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        #1;
        fast_req = fast_valid && (fast_rd != 0);
        e_ready  = !rst && !fast_req;
        acc      = slow_valid && e_ready;
        hz = issue_valid && ((issue_rs1 != 0 && m_pend[issue_rs1]) ||
                             (issue_rs2 != 0 && m_pend[issue_rs2]) ||
                             (issue_rd  != 0 && m_pend[issue_rd]));
        e_stall = rst || hz || (m_wait == LIMIT);
        if (rst)           begin e_addr = 0;       e_data = 0;         end
        else if (fast_req) begin e_addr = fast_rd; e_data = fast_data; end
        else if (acc)      begin e_addr = slow_rd; e_data = slow_data; end
        else               begin e_addr = 0;       e_data = 0;         end

        check({tag, "_ready"},   {31'd0, slow_ready},  {31'd0, e_ready});
        check({tag, "_stall"},   {31'd0, issue_stall}, {31'd0, e_stall});
        check({tag, "_addr"},    {27'd0, rd_addr},     {27'd0, e_addr});
        if (e_addr != 0) check({tag, "_data"}, rd_data, e_data);
        check({tag, "_pending"}, pending, rst ? 32'd0 : m_pend);
        last_acc = acc;

        @(posedge clk);
        if (rst) begin
            m_pend = 0;
            m_wait = 0;
        end else begin
            if (acc && slow_rd != 0) m_pend[slow_rd] = 1'b0;
            if (issue_valid && !e_stall && issue_long && issue_rd != 0) m_pend[issue_rd] = 1'b1;
            if (!slow_valid || acc) m_wait = 0;
            else if (m_wait < LIMIT) m_wait = m_wait + 1;
        end
        #1;
    endtask

    initial begin
        m_pend = 0; m_wait = 0; last_acc = 0;
        idle_inputs();
        rst = 1;
        fast_valid = 1; fast_rd = 5'd4; slow_valid = 1; slow_rd = 5'd6; issue_valid = 1;
        step("reset");
        step("reset2");
        idle_inputs();
        rst = 0;
        step("idle");

        // Long issue then RAW hazard, cleared by slow writeback.
        issue_valid = 1; issue_rd = 5; issue_long = 1;
        step("raw_issue");
        idle_inputs(); issue_valid = 1; issue_rs1 = 5;
        #1; check("raw_stall", {31'd0, issue_stall}, 32'd1);
        check("raw_pend", pending, 32'h20);
        step("raw_wait");
        slow_valid = 1; slow_rd = 5; slow_data = 32'hDEADBEEF;
        #1; check("raw_wb_addr", {27'd0, rd_addr}, 32'd5);
        step("raw_wb");
        slow_valid = 0;
        #1; check("raw_release", {31'd0, issue_stall}, 32'd0);
        step("raw_free");

        // Collision: fast wins, slow goes next cycle.
        idle_inputs();
        fast_valid = 1; fast_rd = 3; fast_data = 32'h11;
        slow_valid = 1; slow_rd = 7; slow_data = 32'h77;
        #1; check("col_addr", {27'd0, rd_addr}, 32'd3);
        step("col_fast");
        fast_valid = 0;
        #1; check("col_slow", {27'd0, rd_addr}, 32'd7);
        step("col_slow");

        // Starvation throttle.
        idle_inputs();
        slow_valid = 1; slow_rd = 4; slow_data = 32'hCAFE0004;
        fast_valid = 1; fast_rd = 1; issue_valid = 1; issue_rs1 = 2;
        for (int i = 0; i < LIMIT + 2; i++) begin
            fast_data = $urandom;
            if (i == LIMIT) begin #1; check("starve_stall", {31'd0, issue_stall}, 32'd1); end
            step("starve");
        end
        fast_valid = 0;
        step("starve_acc");
        slow_valid = 0;
        #1; check("starve_release", {31'd0, issue_stall}, 32'd0);
        step("starve_free");

        // Zero register handling.
        idle_inputs();
        issue_valid = 1; issue_rd = 0; issue_long = 1;
        step("zero_issue");
        idle_inputs();
        fast_valid = 1; fast_rd = 0; fast_data = 32'h5;
        slow_valid = 1; slow_rd = 9; slow_data = 32'h99;
        #1; check("zero_fast_slow", {27'd0, rd_addr}, 32'd9);
        step("zero_fast");
        slow_rd = 0; slow_data = 32'h1234;
        step("zero_slow");

        // Reset mid-operation.
        idle_inputs();
        issue_valid = 1; issue_rd = 5; issue_long = 1;
        step("mid_issue");
        idle_inputs();
        fast_valid = 1; fast_rd = 2; slow_valid = 1; slow_rd = 5;
        step("mid_wait");
        rst = 1;
        step("mid_rst");
        rst = 0;
        idle_inputs(); issue_valid = 1; issue_rs1 = 5;
        #1; check("mid_nostall", {31'd0, issue_stall}, 32'd0);
        step("mid_after");

        // Randomized traffic; slow unit holds its request until accepted.
        idle_inputs();
        last_acc = 1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            int fast_pct;
            fast_pct = ((cyc / 60) % 2 == 1) ? 90 : 30;
            rst = ($urandom_range(0, 99) < 2);
            issue_valid = $urandom_range(0, 1);
            issue_rs1   = 5'($urandom_range(0, 7));
            issue_rs2   = 5'($urandom_range(0, 7));
            issue_rd    = 5'($urandom_range(0, 7));
            issue_long  = ($urandom_range(0, 99) < 40);
            fast_valid  = ($urandom_range(0, 99) < fast_pct);
            fast_rd     = 5'($urandom_range(0, 7));
            fast_data   = $urandom;
            if (!slow_valid || last_acc) begin
                slow_valid = $urandom_range(0, 1);
                slow_rd    = 5'($urandom_range(0, 7));
                slow_data  = $urandom;
            end
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
